lsu_subword: RTL

- Load/store unit between the CPU datapath and the word-organised data memory (dmem).
- Converts byte-addressed byte/halfword/word requests into word accesses.
- Sub-word stores are done as read-modify-write; load data is extracted and extended.
- Flags misaligned requests without touching memory; back-pressures the CPU through req_ready.

---
 rtl/lsu_subword.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/lsu_subword.sv
// Load/store unit: byte/half/word requests to a word-organised dmem, with RMW sub-word stores.
// Optional LSU_SIGNEXT_EN: honour req_signed on sub-word loads (otherwise zero-extend).
module lsu_subword #(
  parameter int WIDTH     = 32,
  parameter int BYTE_OFFS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, LD, RMW_RD, WR} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_addr, r_wdata, r_mem_wd, r_rdata;
  logic [1:0]       r_size;
  logic             r_resp_valid, r_resp_err;
  logic             w_accept, w_misalign, w_sign;
  logic [4:0]       w_shamt;
  logic [WIDTH-1:0] w_shifted, w_load, w_mask, w_lane, w_merge;

  assign w_accept   = req_valid & req_ready;
  assign w_misalign = (req_size == 2'b11) ||
                      (req_size == SZ_HALF && req_addr[0]) ||
                      (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

`ifdef LSU_SIGNEXT_EN
  logic r_signed;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_signed <= 1'b0;
    else if (w_accept) r_signed <= req_signed;
  end
  assign w_sign = r_signed;
`else
  logic w_unused_signed;
  assign w_unused_signed = req_signed;
  assign w_sign = 1'b0;
`endif

  // Lane extraction for loads and lane merge for sub-word stores share one shift amount.
  assign w_shamt   = {r_addr[1:0], 3'b000};
  assign w_shifted = mem_rd >> w_shamt;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_load = w_shifted;
    w_mask = '1;
    w_lane = r_wdata;
    case (r_size)
      SZ_BYTE: begin
        w_load = {{24{w_sign & w_shifted[7]}}, w_shifted[7:0]};
        w_mask = 32'h0000_00FF << w_shamt;
        w_lane = {24'b0, r_wdata[7:0]} << w_shamt;
      end
      SZ_HALF: begin
        w_load = {{16{w_sign & w_shifted[15]}}, w_shifted[15:0]};
        w_mask = 32'h0000_FFFF << w_shamt;
        w_lane = {16'b0, r_wdata[15:0]} << w_shamt;
      end
      default: ;
    endcase
  end

  assign w_merge = (mem_rd & ~w_mask) | (w_lane & w_mask);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept && !w_misalign) begin
        if (!req_we)                  w_next = LD;
        else if (req_size == SZ_WORD) w_next = WR;
        else                          w_next = RMW_RD;
      end
      LD:      w_next = IDLE;
      RMW_RD:  w_next = WR;
      WR:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req_ready = (r_state == IDLE);
    mem_we    = (r_state == WR);
  end

  // Request latch, write-data build and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_size       <= '0;
      r_wdata      <= '0;
      r_mem_wd     <= '0;
      r_rdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_size  <= req_size;
        r_wdata <= req_wdata;
        if (w_misalign) begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
          r_rdata      <= '0;
        end else if (req_we && req_size == SZ_WORD) begin
          r_mem_wd <= req_wdata;
        end
      end
      case (r_state)
        LD: begin
          r_resp_valid <= 1'b1;
          r_rdata      <= w_load;
        end
        RMW_RD: r_mem_wd <= w_merge;
        WR: begin
          r_resp_valid <= 1'b1;
          r_rdata      <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = {{BYTE_OFFS{1'b0}}, r_addr[WIDTH-1:BYTE_OFFS]};
  assign mem_wd     = r_mem_wd;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_rdata;

endmodule
